// File: rtl/seq_multiplier16.sv
`default_nettype none
// ============================================================================
// Module   : seq_multiplier16
// Brief    : Signed shift-add multiplier. Handles one multiplier bit per clock
//            and pulses done once the registered 2*WIDTH-bit product is ready.
// Revision : 1.0 - initial release
// ============================================================================
module seq_multiplier16 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] product_hi,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        lo_d     = lo_q;
        hi_d     = hi_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        sum      = '0;
        prod     = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Two's-complement negate also maps the most negative value onto its magnitude
                    mcand_d  = a[WIDTH-1] ? (~a + 1'b1) : a;
                    mplier_d = b[WIDTH-1] ? (~b + 1'b1) : b;
                    neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
                    acc_d    = '0;
                    cnt_d    = CW'(WIDTH);
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                         + ({1'b0, mcand_q} & {(WIDTH+1){mplier_q[0]}});
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                prod    = neg_q ? (~acc_q + 1'b1) : acc_q;
                lo_d    = prod[WIDTH-1:0];
                hi_d    = prod[2*WIDTH-1:WIDTH];
                // The result fits in WIDTH bits only if the upper half is a sign extension of bit WIDTH-1
                ovf_d   = (|prod[2*WIDTH-1:WIDTH-1]) && !(&prod[2*WIDTH-1:WIDTH-1]);
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign product_lo = lo_q;
    assign product_hi = hi_q;
    assign overflow   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_multiplier16.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_multiplier16
// Brief    : Self-checking bench for seq_multiplier16. It compares the DUT
//            against a reference model of products and latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_multiplier16;

    localparam int WIDTH = 16;
    localparam int LAT   = WIDTH + 1;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_lo;
    logic [WIDTH-1:0] product_hi;
    logic             overflow;

    int n_cmp = 0;
    int n_err = 0;

    seq_multiplier16 #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product_lo (product_lo),
        .product_hi (product_hi),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Reference model: an accepted start produces a*b exactly LAT edges later.
    int          rem;
    logic [31:0] pend_p;
    logic        exp_busy, exp_done, exp_ovf;
    logic [15:0] exp_lo, exp_hi;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      = 0;
            pend_p   = '0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_ovf  = 1'b0;
            exp_lo   = '0;
            exp_hi   = '0;
        end else begin
            exp_done = 1'b0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    exp_done = 1'b1;
                    exp_busy = 1'b0;
                    exp_lo   = pend_p[15:0];
                    exp_hi   = pend_p[31:16];
                    exp_ovf  = ($signed(pend_p) > 32767) || ($signed(pend_p) < -32768);
                end
            end else if (start) begin
                longint p;
                p        = longint'($signed(a)) * longint'($signed(b));
                pend_p   = p[31:0];
                rem      = LAT;
                exp_busy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        check("busy", {31'd0, busy}, {31'd0, exp_busy});
        check("done", {31'd0, done}, {31'd0, exp_done});
        check("lo",   {16'd0, product_lo}, {16'd0, exp_lo});
        check("hi",   {16'd0, product_hi}, {16'd0, exp_hi});
        check("ovf",  {31'd0, overflow}, {31'd0, exp_ovf});
    end

    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic start_op(input logic [15:0] x, input logic [15:0] y);
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic op_check(input string nm, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] elo, input logic [15:0] ehi, input logic eovf);
        int n;
        start_op(x, y);
        wait_done(n);
        check({nm, "_lat"}, n, LAT);
        check({nm, "_lo"}, {16'd0, product_lo}, {16'd0, elo});
        check({nm, "_hi"}, {16'd0, product_hi}, {16'd0, ehi});
        check({nm, "_ovf"}, {31'd0, overflow}, {31'd0, eovf});
        #2;
    endtask

    task automatic expect_no_done(input string nm, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            check(nm, {31'd0, done}, 32'd0);
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_lo", {16'd0, product_lo}, 32'd0);
        check("rst_hi", {16'd0, product_hi}, 32'd0);
        @(posedge clk);
        #2;

        op_check("small", 16'd3, 16'd5, 16'h000F, 16'h0000, 1'b0);
        op_check("mixed", 16'hFFF9, 16'd6, 16'hFFD6, 16'hFFFF, 1'b0);
        op_check("ovf300", 16'd300, 16'd300, 16'h5F90, 16'h0001, 1'b1);
        op_check("minmin", 16'h8000, 16'h8000, 16'h0000, 16'h4000, 1'b1);

        // A start pulse while busy must be ignored
        start_op(16'd2, 16'd2);
        repeat (3) @(posedge clk);
        #2;
        start = 1'b1; a = 16'd9; b = 16'd9;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done(n);
        check("busy_start_lat", n, LAT - 4);
        check("busy_start_lo", {16'd0, product_lo}, 32'h0004);
        expect_no_done("busy_start_nodone", 25);

        // Back-to-back: the second start is applied during the done cycle
        start_op(16'hFFFF, 16'hFFFF);
        wait_done(n);
        check("b2b1_lat", n, LAT);
        check("b2b1_lo", {16'd0, product_lo}, 32'h0001);
        start = 1'b1; a = 16'h7FFF; b = 16'd2;
        @(posedge clk);
        #2;
        start = 1'b0;
        wait_done(n);
        check("b2b2_lat", n, LAT);
        check("b2b2_lo", {16'd0, product_lo}, 32'hFFFE);
        check("b2b2_hi", {16'd0, product_hi}, 32'h0000);
        check("b2b2_ovf", {31'd0, overflow}, 32'd1);
        #2;

        // An asynchronous reset mid-operation aborts the operation and clears results
        start_op(16'd100, 16'd100);
        repeat (6) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_lo", {16'd0, product_lo}, 32'd0);
        check("arst_hi", {16'd0, product_hi}, 32'd0);
        check("arst_ovf", {31'd0, overflow}, 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        expect_no_done("arst_nodone", 25);
        op_check("after_rst", 16'd4, 16'hFFFC, 16'hFFF0, 16'hFFFF, 1'b0);

        // Randomized traffic, including starts while busy and corner operands
        for (int i = 0; i < 600; i++) begin
            @(posedge clk);
            #2;
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 7))
                0:       a = 16'h8000;
                1:       a = 16'h7FFF;
                2:       a = 16'h0000;
                3:       a = 16'hFFFF;
                default: a = 16'($urandom);
            endcase
            case ($urandom_range(0, 7))
                0:       b = 16'h8000;
                1:       b = 16'h0001;
                2:       b = 16'h0000;
                3:       b = 16'hFFFF;
                default: b = 16'($urandom);
            endcase
        end
        start = 1'b0;
        repeat (LAT + 3) @(posedge clk);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
